zstr_drain: RTL and testbench

ZSTR_DRAIN -- requirements
Module: zstr_drain

---
 rtl/zstr_drain.sv | 150 +++++++++++++++
 tb/tb_zstr_drain.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/zstr_drain.sv
// Stream drain/checker: acknowledges transfers, compares data against an incrementing expected word.
// Optional idle timeout is compiled in with ZSTR_DRAIN_TIMEOUT_EN.
module zstr_drain #(
  parameter int unsigned BW   = 8,
  parameter int unsigned LW   = 16,
  parameter int unsigned BP   = 0,
  parameter logic [15:0] SEED = 16'hACE1,
  parameter int unsigned TMO  = 64
) (
  input  logic          z_clk,
  input  logic          z_rst,
  input  logic          z_vld,
  input  logic [BW-1:0] z_bus,
  output logic          z_ack,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [BW-1:0] base,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] trn_cnt,
  output logic [15:0]   err_cnt,
  output logic          err,
  output logic          tmo
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] exp_q, exp_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] trn_q, trn_d;
  logic [15:0]   errc_q, errc_d;
  logic          err_q, err_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          rdy;
  logic          xfer;
  logic          mismatch;

`ifdef ZSTR_DRAIN_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TMO + 1);
  logic [IW-1:0] idle_q, idle_d;
  logic          tmo_q, tmo_d;
`endif

  // Ready depends on registered state only, so z_ack never follows z_vld combinationally.
  assign rdy      = (BP == 0) ? 1'b1 : (lfsr_q[0] | lfsr_q[1]);
  assign z_ack    = (state_q == StRun) & rdy;
  assign xfer     = z_ack & z_vld;
  // Case inequality so X/Z on the bus counts as a mismatch in simulation.
  assign mismatch = (z_bus !== exp_q);

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StDone);
  assign trn_cnt = trn_q;
  assign err_cnt = errc_q;
  assign err     = err_q;
`ifdef ZSTR_DRAIN_TIMEOUT_EN
  assign tmo     = tmo_q;
`else
  assign tmo     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    len_d   = len_q;
    trn_d   = trn_q;
    errc_d  = errc_q;
    err_d   = err_q;
    lfsr_d  = lfsr_q;
`ifdef ZSTR_DRAIN_TIMEOUT_EN
    idle_d  = idle_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          exp_d   = base;
          len_d   = len;
          trn_d   = '0;
          errc_d  = '0;
          err_d   = 1'b0;
`ifdef ZSTR_DRAIN_TIMEOUT_EN
          idle_d  = '0;
          tmo_d   = 1'b0;
`endif
          state_d = (len == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        if (xfer) begin
          trn_d = trn_q + 1'b1;
          exp_d = exp_q + 1'b1;
          if (mismatch) begin
            err_d = 1'b1;
            if (errc_q != 16'hFFFF) errc_d = errc_q + 16'd1;
          end
`ifdef ZSTR_DRAIN_TIMEOUT_EN
          idle_d = '0;
`endif
          if (trn_d == len_q) state_d = StDone;
        end
`ifdef ZSTR_DRAIN_TIMEOUT_EN
        else begin
          idle_d = idle_q + 1'b1;
          if (idle_d == IW'(TMO)) begin
            tmo_d   = 1'b1;
            state_d = StDone;
          end
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      state_q <= StIdle;
      exp_q   <= '0;
      len_q   <= '0;
      trn_q   <= '0;
      errc_q  <= '0;
      err_q   <= 1'b0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      len_q   <= len_d;
      trn_q   <= trn_d;
      errc_q  <= errc_d;
      err_q   <= err_d;
      lfsr_q  <= lfsr_d;
    end
  end

`ifdef ZSTR_DRAIN_TIMEOUT_EN
  always_ff @(posedge z_clk or posedge z_rst) begin
    if (z_rst) begin
      idle_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      idle_q <= idle_d;
      tmo_q  <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_zstr_drain.sv
// Scoreboard bench for zstr_drain: one always-ready instance and one pseudo-random-ready instance.
module tb_zstr_drain;

  logic        z_clk, z_rst, z_vld;
  logic [7:0]  z_bus, base;
  logic [15:0] len;
  logic        start0, start1;
  logic        ack0, busy0, done0, err0, tmo0;
  logic        ack1, busy1, done1, err1, tmo1;
  logic [15:0] trn0, errc0, trn1, errc1;

  typedef struct packed {
    logic [15:0] trn;
    logic [15:0] errc;
    logic        err;
    logic        tmo;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  int   ntests = 0;
  int   nfail  = 0;
  logic done0_prev = 1'b0;
  logic done1_prev = 1'b0;

  zstr_drain #(.BW(8), .LW(16), .BP(0)) dut0 (
    .z_clk(z_clk), .z_rst(z_rst), .z_vld(z_vld), .z_bus(z_bus), .z_ack(ack0),
    .start(start0), .len(len), .base(base), .busy(busy0), .done(done0),
    .trn_cnt(trn0), .err_cnt(errc0), .err(err0), .tmo(tmo0)
  );

  zstr_drain #(.BW(8), .LW(16), .BP(1)) dut1 (
    .z_clk(z_clk), .z_rst(z_rst), .z_vld(z_vld), .z_bus(z_bus), .z_ack(ack1),
    .start(start1), .len(len), .base(base), .busy(busy1), .done(done1),
    .trn_cnt(trn1), .err_cnt(errc1), .err(err1), .tmo(tmo1)
  );

  initial begin
    z_clk = 1'b0;
    forever #5 z_clk = ~z_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input logic [15:0] t, input logic [15:0] ec, input logic e,
                      input logic to);
    res_t r;
    r.trn = t; r.errc = ec; r.err = e; r.tmo = to;
    if (sel == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  // Monitor: each completed run (rising done) is compared against the oldest queued result.
  always @(negedge z_clk) begin
    res_t r;
    done0_prev <= done0;
    done1_prev <= done1;
    if (done0 && !done0_prev) begin
      if (q0.size() == 0) chk("sb0_unexpected_done", 32'd1, 32'd0);
      else begin
        r = q0.pop_front();
        chk("sb0_trn_cnt", 32'(trn0), 32'(r.trn));
        chk("sb0_err_cnt", 32'(errc0), 32'(r.errc));
        chk("sb0_err", 32'(err0), 32'(r.err));
        chk("sb0_tmo", 32'(tmo0), 32'(r.tmo));
      end
    end
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) chk("sb1_unexpected_done", 32'd1, 32'd0);
      else begin
        r = q1.pop_front();
        chk("sb1_trn_cnt", 32'(trn1), 32'(r.trn));
        chk("sb1_err_cnt", 32'(errc1), 32'(r.errc));
        chk("sb1_err", 32'(err1), 32'(r.err));
        chk("sb1_tmo", 32'(tmo1), 32'(r.tmo));
      end
    end
  end

  task automatic do_start(input int sel, input logic [15:0] l, input logic [7:0] b);
    @(negedge z_clk);
    if (sel == 0) start0 = 1'b1;
    else start1 = 1'b1;
    len  = l;
    base = b;
    @(negedge z_clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Source holding z_vld; advances only after an edge where ack was high. Called at a negedge.
  task automatic run_stream(input int sel, input int n, input logic [7:0] first, input int bad_idx,
                            input logic [7:0] bad_val, input int budget,
                            output int ack_cyc, output int low_cyc, output int ack_mis);
    int          idx = 0;
    int          cyc = 0;
    logic        a;
    logic [15:0] m = 16'hACE1;
    ack_cyc = 0; low_cyc = 0; ack_mis = 0;
    while (idx < n && cyc < budget) begin
      z_vld = 1'b1;
      z_bus = (idx == bad_idx) ? bad_val : first + 8'(idx);
      a = (sel == 0) ? ack0 : ack1;
      if (a) ack_cyc++;
      else low_cyc++;
      if (sel == 1) begin
        if (a !== (m[0] | m[1])) ack_mis++;
        m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      end
      @(negedge z_clk);
      cyc++;
      if (a) idx++;
    end
    z_vld = 1'b0;
    chk("stream_xfers", 32'(idx), 32'(n));
  endtask

  initial begin
    int ac, lc, am, seen;
    z_rst = 1'b1; z_vld = 1'b0; z_bus = 8'h00; start0 = 1'b0; start1 = 1'b0;
    len = 16'd0; base = 8'h00;
    repeat (3) @(negedge z_clk);
    z_rst = 1'b0;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ack", 32'(ack0), 32'd0);
    chk("rst_trn", 32'(trn0), 32'd0);
    chk("rst_errc", 32'(errc0), 32'd0);
    chk("rst_err_tmo", 32'({err0, tmo0}), 32'd0);

    // len=0: straight to DONE, never acks
    push(0, 16'd0, 16'd0, 1'b0, 1'b0);
    do_start(0, 16'd0, 8'h55);
    chk("len0_done", 32'(done0), 32'd1);
    chk("len0_busy", 32'(busy0), 32'd0);
    seen = 0;
    z_vld = 1'b1;
    repeat (3) begin
      if (ack0) seen++;
      @(negedge z_clk);
    end
    z_vld = 1'b0;
    chk("len0_ack_never", 32'(seen), 32'd0);

    // Back-to-back 10..13
    push(0, 16'd4, 16'd0, 1'b0, 1'b0);
    do_start(0, 16'd4, 8'h10);
    run_stream(0, 4, 8'h10, -1, 8'h00, 50, ac, lc, am);
    chk("b2b_ack_cycles", 32'(ac), 32'd4);
    chk("b2b_ack_low", 32'(lc), 32'd0);
    chk("b2b_done_next", 32'(done0), 32'd1);
    chk("b2b_ack_off", 32'(ack0), 32'd0);

    // Expected-word wrap FE,FF,00 clean; then FE,FF,01 mismatches once
    push(0, 16'd3, 16'd0, 1'b0, 1'b0);
    do_start(0, 16'd3, 8'hFE);
    run_stream(0, 3, 8'hFE, -1, 8'h00, 50, ac, lc, am);
    push(0, 16'd3, 16'd1, 1'b1, 1'b0);
    do_start(0, 16'd3, 8'hFE);
    run_stream(0, 3, 8'hFE, 2, 8'h01, 50, ac, lc, am);

    // start while busy is ignored; expected word keeps going from 22
    push(0, 16'd5, 16'd0, 1'b0, 1'b0);
    do_start(0, 16'd5, 8'h20);
    run_stream(0, 2, 8'h20, -1, 8'h00, 50, ac, lc, am);
    do_start(0, 16'd9, 8'h00);
    chk("busy_start_trn", 32'(trn0), 32'd2);
    chk("busy_start_busy", 32'(busy0), 32'd1);
    run_stream(0, 3, 8'h22, -1, 8'h00, 50, ac, lc, am);

    // Asynchronous reset after 2 of 5 transfers
    do_start(0, 16'd5, 8'h30);
    run_stream(0, 2, 8'h30, -1, 8'h00, 50, ac, lc, am);
    z_vld = 1'b1;
    z_bus = 8'h32;
    #2 z_rst = 1'b1;
    #1;
    chk("arst_ack", 32'(ack0), 32'd0);
    chk("arst_trn", 32'(trn0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    @(negedge z_clk);
    z_rst = 1'b0;
    @(negedge z_clk);
    z_vld = 1'b0;
    chk("arst_trn_held", 32'(trn0), 32'd0);
    chk("arst_stay_idle", 32'({busy0, done0}), 32'd0);

    // Pseudo-random backpressure, 100 incrementing words
    push(1, 16'd100, 16'd0, 1'b0, 1'b0);
    do_start(1, 16'd100, 8'h00);
    run_stream(1, 100, 8'h00, -1, 8'h00, 1000, ac, lc, am);
    chk("bp1_ack_cycles", 32'(ac), 32'd100);
    chk("bp1_has_low", 32'(lc > 0), 32'd1);
    chk("bp1_ack_pattern", 32'(am), 32'd0);
    chk("bp1_done", 32'(done1), 32'd1);

    // Idle source
`ifdef ZSTR_DRAIN_TIMEOUT_EN
    push(0, 16'd0, 16'd0, 1'b0, 1'b1);
    do_start(0, 16'd5, 8'h40);
    repeat (63) @(negedge z_clk);
    chk("tmo_before", 32'({busy0, done0}), 32'd2);
    @(negedge z_clk);
    chk("tmo_done", 32'(done0), 32'd1);
    chk("tmo_flag", 32'(tmo0), 32'd1);
`else
    do_start(0, 16'd5, 8'h40);
    repeat (200) @(negedge z_clk);
    chk("notmo_busy", 32'(busy0), 32'd1);
    chk("notmo_flag", 32'(tmo0), 32'd0);
    chk("notmo_done", 32'(done0), 32'd0);
`endif

    repeat (2) @(negedge z_clk);
    chk("sb0_drained", 32'(q0.size()), 32'd0);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
